// File: rtl/tag_tx_sweep.sv
// Stepped-frequency TX phase scheduler: emits one DDS phase word per beat over
// NSYMB symbols of NSIG samples, with optional blanked gaps between sweeps.
module tag_tx_sweep #(
  parameter int                     PHASE_WIDTH  = 24,
  parameter int                     NSYMB_WIDTH  = 16,
  parameter int                     NSWEEP_WIDTH = 8,
  parameter int                     NSYMB        = 512,
  parameter int                     NSIG         = 32768,
  parameter int                     GAP_LEN      = 0,
  parameter logic [PHASE_WIDTH-1:0] START_PH     = '0,
  parameter logic [PHASE_WIDTH-1:0] START_PH_INC = '0,
  parameter int                     DPH_INC      = -16384,
  parameter logic [PHASE_WIDTH-1:0] NPH_SHIFT    = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    srst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [NSWEEP_WIDTH-1:0] nsweeps,
  output logic [PHASE_WIDTH-1:0]  phase_tdata,
  output logic                    phase_tvalid,
  output logic                    phase_tlast,
  input  logic                    phase_tready,
  output logic                    tx_gate,
  output logic [NSYMB_WIDTH-1:0]  symb_idx,
  output logic [PHASE_WIDTH-1:0]  samp_idx,
  output logic [NSWEEP_WIDTH-1:0] sweep_cnt,
  output logic                    busy,
  output logic                    sweep_done,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  localparam logic [PHASE_WIDTH-1:0] NSIG_W  = PHASE_WIDTH'(NSIG);
  localparam logic [PHASE_WIDTH-1:0] GAP_W   = PHASE_WIDTH'(GAP_LEN);
  localparam logic [PHASE_WIDTH-1:0] DPH_W   = PHASE_WIDTH'(DPH_INC);
  localparam logic [NSYMB_WIDTH-1:0] NSYMB_W = NSYMB_WIDTH'(NSYMB);
  localparam logic [PHASE_WIDTH-1:0] ONE_PH  = PHASE_WIDTH'(1);
  localparam logic [NSYMB_WIDTH-1:0] ONE_SY  = NSYMB_WIDTH'(1);

  state_e                    state_q, state_d;
  logic [PHASE_WIDTH-1:0]    phase_q, phase_d;
  logic [PHASE_WIDTH-1:0]    inc_q, inc_d;
  logic [PHASE_WIDTH-1:0]    sphase_q, sphase_d;
  logic [PHASE_WIDTH-1:0]    samp_q, samp_d;
  logic [NSYMB_WIDTH-1:0]    symb_q, symb_d;
  logic [NSWEEP_WIDTH-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic [NSWEEP_WIDTH-1:0]   nsweeps_q, nsweeps_d;
  logic                      stop_q, stop_d;
  logic                      done_q, done_d;

  logic                      beat;
  logic                      last_samp;
  logic                      last_symb;
  logic                      sweep_end;
  logic                      gap_end;
  logic                      stop_req;
  logic                      halt_cnt;
  logic [NSWEEP_WIDTH-1:0]   cnt_inc;

  // Handshake: a beat is phase_tvalid && phase_tready. Valid is a pure function
  // of state, and tdata/tlast/tx_gate come only from registers that change on a
  // beat, so the word holds steady while the DDS stalls; only reset drops valid.
  assign beat      = phase_tvalid && phase_tready;
  assign last_samp = (samp_q == NSIG_W);
  assign last_symb = (symb_q == NSYMB_W);
  assign sweep_end = (state_q == S_SWEEP) && beat && last_samp && last_symb;
  assign gap_end   = (state_q == S_GAP) && beat && (samp_q == GAP_W);
  assign stop_req  = stop_q || stop;
  assign cnt_inc   = sweep_cnt_q + 1'b1;
  assign halt_cnt  = (nsweeps_q != '0) && (cnt_inc == nsweeps_q);

  // State and datapath register.
  always_ff @(posedge clk) begin
    if (reset || srst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      inc_q       <= '0;
      sphase_q    <= '0;
      samp_q      <= ONE_PH;
      symb_q      <= ONE_SY;
      sweep_cnt_q <= '0;
      nsweeps_q   <= '0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      inc_q       <= inc_d;
      sphase_q    <= sphase_d;
      samp_q      <= samp_d;
      symb_q      <= symb_d;
      sweep_cnt_q <= sweep_cnt_d;
      nsweeps_q   <= nsweeps_d;
      stop_q      <= stop_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SWEEP;
      end
      S_SWEEP: begin
        if (sweep_end) begin
          if (stop_req || halt_cnt) state_d = S_IDLE;
          else if (GAP_LEN > 0)     state_d = S_GAP;
          else                      state_d = S_SWEEP;
        end
      end
      S_GAP: begin
        if (gap_end) state_d = stop_req ? S_IDLE : S_SWEEP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; the schedule reloads at each sweep end so a gap or
  // back-to-back sweep resumes from symbol 1 without extra bookkeeping.
  always_comb begin
    phase_d     = phase_q;
    inc_d       = inc_q;
    sphase_d    = sphase_q;
    samp_d      = samp_q;
    symb_d      = symb_q;
    sweep_cnt_d = sweep_cnt_q;
    nsweeps_d   = nsweeps_q;
    stop_d      = stop_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          phase_d     = START_PH;
          inc_d       = START_PH_INC;
          sphase_d    = START_PH;
          samp_d      = ONE_PH;
          symb_d      = ONE_SY;
          sweep_cnt_d = '0;
          nsweeps_d   = nsweeps;
        end
      end
      S_SWEEP: begin
        if (stop) stop_d = 1'b1;
        if (beat) begin
          if (!last_samp) begin
            phase_d = phase_q + inc_q;
            samp_d  = samp_q + 1'b1;
          end else if (!last_symb) begin
            samp_d   = ONE_PH;
            symb_d   = symb_q + 1'b1;
            inc_d    = inc_q + DPH_W;
            sphase_d = sphase_q - NPH_SHIFT;
            phase_d  = sphase_q - NPH_SHIFT;
          end else begin
            done_d      = 1'b1;
            sweep_cnt_d = cnt_inc;
            phase_d     = START_PH;
            inc_d       = START_PH_INC;
            sphase_d    = START_PH;
            samp_d      = ONE_PH;
            symb_d      = ONE_SY;
          end
        end
      end
      S_GAP: begin
        if (stop) stop_d = 1'b1;
        if (beat) samp_d = gap_end ? ONE_PH : samp_q + 1'b1;
      end
      default: ;
    endcase
    if ((state_d == S_IDLE) && (state_q != S_IDLE)) stop_d = 1'b0;
  end

  // Output decode.
  always_comb begin
    phase_tvalid = (state_q != S_IDLE);
    busy         = (state_q != S_IDLE);
    tx_gate      = (state_q == S_SWEEP);
    phase_tdata  = (state_q == S_SWEEP) ? phase_q : '0;
    phase_tlast  = (state_q == S_SWEEP) && last_samp;
    symb_idx     = symb_q;
    samp_idx     = samp_q;
    sweep_cnt    = sweep_cnt_q;
    sweep_done   = done_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_tag_tx_sweep.sv
// Directed bench for tag_tx_sweep: schedule, gap/repeat, backpressure, wrap,
// stop and mid-sweep soft reset, against hand-computed phase tables.
module tb_tag_tx_sweep;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        srst = 1'b0;
  logic        a_start = 1'b0, a_stop = 1'b0, a_ready = 1'b0;
  logic [7:0]  a_nsw = '0;
  logic [23:0] a_data, a_samp;
  logic        a_valid, a_last, a_gate, a_busy, a_done;
  logic [15:0] a_symb;
  logic [7:0]  a_cnt;
  logic [1:0]  a_dbg;
  logic        b_start = 1'b0, b_stop = 1'b0, b_ready = 1'b0;
  logic [7:0]  b_nsw = '0;
  logic [23:0] b_data, b_samp;
  logic        b_valid, b_last, b_gate, b_busy, b_done;
  logic [15:0] b_symb;
  logic [7:0]  b_cnt;
  logic [1:0]  b_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] q_data[$];
  logic        q_last[$];
  logic        q_gate[$];
  logic [15:0] q_symb[$];
  logic [23:0] q_samp[$];
  logic [23:0] exp_q[$];
  int done_cnt, extra, stab_bad, cyc;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  tag_tx_sweep #(
    .NSYMB(3), .NSIG(4), .GAP_LEN(2), .START_PH(24'h000000),
    .START_PH_INC(24'd100), .DPH_INC(50), .NPH_SHIFT(24'd10)
  ) dut_a (
    .clk(clk), .reset(reset), .srst(srst), .start(a_start), .stop(a_stop),
    .nsweeps(a_nsw), .phase_tdata(a_data), .phase_tvalid(a_valid),
    .phase_tlast(a_last), .phase_tready(a_ready), .tx_gate(a_gate),
    .symb_idx(a_symb), .samp_idx(a_samp), .sweep_cnt(a_cnt), .busy(a_busy),
    .sweep_done(a_done), .dbg_state(a_dbg)
  );

  tag_tx_sweep #(
    .NSYMB(2), .NSIG(2), .GAP_LEN(0), .START_PH(24'hFFFFF0),
    .START_PH_INC(24'h000020), .DPH_INC(16), .NPH_SHIFT(24'h000000)
  ) dut_b (
    .clk(clk), .reset(reset), .srst(srst), .start(b_start), .stop(b_stop),
    .nsweeps(b_nsw), .phase_tdata(b_data), .phase_tvalid(b_valid),
    .phase_tlast(b_last), .phase_tready(b_ready), .tx_gate(b_gate),
    .symb_idx(b_symb), .samp_idx(b_samp), .sweep_cnt(b_cnt), .busy(b_busy),
    .sweep_done(b_done), .dbg_state(b_dbg)
  );

  function automatic logic [23:0] sched_ph(input int i);
    case (i)
      0: return 24'd0;       1: return 24'd100;  2: return 24'd200;  3: return 24'd300;
      4: return 24'hFFFFF6;  5: return 24'd140;  6: return 24'd290;  7: return 24'd440;
      8: return 24'hFFFFEC;  9: return 24'd180;  10: return 24'd380; default: return 24'd580;
    endcase
  endfunction

  // driver tasks
  task automatic do_start(input bit sel, input logic [7:0] ns);
    @(negedge clk);
    if (sel) begin b_start = 1'b1; b_nsw = ns; end
    else     begin a_start = 1'b1; a_nsw = ns; end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  // Collect nbeats handshakes (ready at duty%), then tail cycles with ready=1.
  task automatic run(input bit sel, input int nbeats, input int duty,
                     input int tail, input int max_cyc);
    logic v, l, g, rdy, pv, pr, pl, pg;
    logic [23:0] d, pd;
    q_data.delete(); q_last.delete(); q_gate.delete();
    q_symb.delete(); q_samp.delete();
    done_cnt = 0; extra = 0; stab_bad = 0; cyc = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pg = 1'b0; pd = '0;
    while (q_data.size() < nbeats && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      v = sel ? b_valid : a_valid;
      d = sel ? b_data  : a_data;
      l = sel ? b_last  : a_last;
      g = sel ? b_gate  : a_gate;
      if (sel ? b_done : a_done) done_cnt++;
      if (pv && !pr && (!v || d !== pd || l !== pl || g !== pg)) stab_bad++;
      rdy = (duty >= 100) ? 1'b1 : ($urandom_range(99, 0) < duty);
      if (sel) b_ready = rdy; else a_ready = rdy;
      if (v && rdy) begin
        q_data.push_back(d); q_last.push_back(l); q_gate.push_back(g);
        q_symb.push_back(sel ? b_symb : a_symb);
        q_samp.push_back(sel ? b_samp : a_samp);
      end
      pv = v; pr = rdy; pd = d; pl = l; pg = g;
    end
    @(posedge clk); #1;
    a_ready = 1'b0; b_ready = 1'b0;
    for (int t = 0; t < tail; t++) begin
      @(negedge clk);
      if (sel ? b_done : a_done) done_cnt++;
      if (sel ? b_valid : a_valid) extra++;
      if (sel) b_ready = 1'b1; else a_ready = 1'b1;
      @(posedge clk); #1;
      a_ready = 1'b0; b_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp += 9;
    if (a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", a_valid); end
    if (a_data !== 24'd0) begin n_bad++; $display("FAIL reset_tdata got %h want 0", a_data); end
    if (a_last !== 1'b0) begin n_bad++; $display("FAIL reset_tlast got %b want 0", a_last); end
    if (a_gate !== 1'b0) begin n_bad++; $display("FAIL reset_gate got %b want 0", a_gate); end
    if (a_symb !== 16'd1) begin n_bad++; $display("FAIL reset_symb got %0d want 1", a_symb); end
    if (a_samp !== 24'd1) begin n_bad++; $display("FAIL reset_samp got %0d want 1", a_samp); end
    if (a_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_sweep_cnt got %0d want 0", a_cnt); end
    if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", a_busy); end
    if (a_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", a_done); end
  endtask

  task automatic test_schedule();
    do_start(1'b0, 8'd1);
    n_cmp += 2;
    if (a_valid !== 1'b1) begin n_bad++; $display("FAIL start_latency valid got %b want 1", a_valid); end
    if (a_data !== 24'd0) begin n_bad++; $display("FAIL start_first_data got %h want 0", a_data); end
    run(1'b0, 12, 100, 3, 200);
    for (int i = 0; i < 12; i++) exp_q.push_back(sched_ph(i));
    n_cmp++;
    if (q_data.size() !== 12) begin n_bad++; $display("FAIL sched_beats got %0d want 12", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 12; i++) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      n_cmp += 5;
      if (q_data[i] !== e) begin n_bad++; $display("FAIL sched_data[%0d] got %h want %h", i, q_data[i], e); end
      if (q_last[i] !== (i % 4 == 3)) begin n_bad++; $display("FAIL sched_last[%0d] got %b want %b", i, q_last[i], (i % 4 == 3)); end
      if (q_gate[i] !== 1'b1) begin n_bad++; $display("FAIL sched_gate[%0d] got %b want 1", i, q_gate[i]); end
      if (q_symb[i] !== 16'(i / 4 + 1)) begin n_bad++; $display("FAIL sched_symb[%0d] got %0d want %0d", i, q_symb[i], i / 4 + 1); end
      if (q_samp[i] !== 24'(i % 4 + 1)) begin n_bad++; $display("FAIL sched_samp[%0d] got %0d want %0d", i, q_samp[i], i % 4 + 1); end
    end
    exp_q.delete();
    n_cmp += 4;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL sched_done got %0d want 1", done_cnt); end
    if (extra !== 0) begin n_bad++; $display("FAIL sched_extra_beats got %0d want 0", extra); end
    if (a_busy !== 1'b0) begin n_bad++; $display("FAIL sched_busy_end got %b want 0", a_busy); end
    if (a_cnt !== 8'd1) begin n_bad++; $display("FAIL sched_sweep_cnt got %0d want 1", a_cnt); end
  endtask

  task automatic test_gap_repeat();
    do_start(1'b0, 8'd2);
    run(1'b0, 26, 100, 3, 300);
    n_cmp++;
    if (q_data.size() !== 26) begin n_bad++; $display("FAIL gap_beats got %0d want 26", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 26; i++) begin
      logic [23:0] ed;
      logic el, eg;
      if (i >= 12 && i < 14) begin ed = 24'd0; el = 1'b0; eg = 1'b0; end
      else begin
        ed = sched_ph(i < 12 ? i : i - 14);
        el = ((i < 12 ? i : i - 14) % 4 == 3);
        eg = 1'b1;
      end
      n_cmp += 3;
      if (q_data[i] !== ed) begin n_bad++; $display("FAIL gap_data[%0d] got %h want %h", i, q_data[i], ed); end
      if (q_last[i] !== el) begin n_bad++; $display("FAIL gap_last[%0d] got %b want %b", i, q_last[i], el); end
      if (q_gate[i] !== eg) begin n_bad++; $display("FAIL gap_gate[%0d] got %b want %b", i, q_gate[i], eg); end
    end
    n_cmp += 4;
    if (done_cnt !== 2) begin n_bad++; $display("FAIL gap_done got %0d want 2", done_cnt); end
    if (extra !== 0) begin n_bad++; $display("FAIL gap_extra_beats got %0d want 0", extra); end
    if (a_cnt !== 8'd2) begin n_bad++; $display("FAIL gap_sweep_cnt got %0d want 2", a_cnt); end
    if (a_busy !== 1'b0) begin n_bad++; $display("FAIL gap_busy_end got %b want 0", a_busy); end
  endtask

  task automatic test_backpressure();
    do_start(1'b0, 8'd1);
    run(1'b0, 12, 30, 3, 2000);
    n_cmp += 3;
    if (q_data.size() !== 12) begin n_bad++; $display("FAIL bp_beats got %0d want 12", q_data.size()); end
    if (stab_bad !== 0) begin n_bad++; $display("FAIL bp_stability got %0d unstable cycles want 0", stab_bad); end
    if (done_cnt !== 1) begin n_bad++; $display("FAIL bp_done got %0d want 1", done_cnt); end
    for (int i = 0; i < q_data.size() && i < 12; i++) begin
      n_cmp += 2;
      if (q_data[i] !== sched_ph(i)) begin n_bad++; $display("FAIL bp_data[%0d] got %h want %h", i, q_data[i], sched_ph(i)); end
      if (q_last[i] !== (i % 4 == 3)) begin n_bad++; $display("FAIL bp_last[%0d] got %b want %b", i, q_last[i], (i % 4 == 3)); end
    end
  endtask

  task automatic test_wrap();
    do_start(1'b1, 8'd2);
    run(1'b1, 8, 100, 3, 100);
    exp_q = '{24'hFFFFF0, 24'h000010, 24'hFFFFF0, 24'h000020,
              24'hFFFFF0, 24'h000010, 24'hFFFFF0, 24'h000020};
    n_cmp += 4;
    if (q_data.size() !== 8) begin n_bad++; $display("FAIL wrap_beats got %0d want 8", q_data.size()); end
    if (cyc !== 8) begin n_bad++; $display("FAIL wrap_no_bubble cycles got %0d want 8", cyc); end
    if (done_cnt !== 2) begin n_bad++; $display("FAIL wrap_done got %0d want 2", done_cnt); end
    if (b_cnt !== 8'd2) begin n_bad++; $display("FAIL wrap_sweep_cnt got %0d want 2", b_cnt); end
    for (int i = 0; i < q_data.size() && i < 8; i++) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      n_cmp += 2;
      if (q_data[i] !== e) begin n_bad++; $display("FAIL wrap_data[%0d] got %h want %h", i, q_data[i], e); end
      if (q_last[i] !== (i % 2 == 1)) begin n_bad++; $display("FAIL wrap_last[%0d] got %b want %b", i, q_last[i], (i % 2 == 1)); end
    end
    exp_q.delete();
  endtask

  task automatic test_stop();
    do_start(1'b0, 8'd0);
    run(1'b0, 5, 100, 0, 100);
    @(negedge clk); a_stop = 1'b1;
    @(negedge clk); a_stop = 1'b0;
    run(1'b0, 7, 100, 4, 100);
    n_cmp += 4;
    if (q_data.size() !== 7) begin n_bad++; $display("FAIL stop_beats got %0d want 7", q_data.size()); end
    if (done_cnt !== 1) begin n_bad++; $display("FAIL stop_done got %0d want 1", done_cnt); end
    if (extra !== 0) begin n_bad++; $display("FAIL stop_gap_beats got %0d want 0", extra); end
    if (a_busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy_end got %b want 0", a_busy); end
    for (int i = 0; i < q_data.size() && i < 7; i++) begin
      n_cmp++;
      if (q_data[i] !== sched_ph(i + 5)) begin n_bad++; $display("FAIL stop_data[%0d] got %h want %h", i, q_data[i], sched_ph(i + 5)); end
    end
  endtask

  task automatic test_srst();
    do_start(1'b0, 8'd0);
    run(1'b0, 5, 100, 0, 100);
    @(negedge clk); a_ready = 1'b1; srst = 1'b1;
    @(negedge clk); a_ready = 1'b0; srst = 1'b0;
    n_cmp += 5;
    if (a_valid !== 1'b0) begin n_bad++; $display("FAIL srst_valid got %b want 0", a_valid); end
    if (a_busy !== 1'b0) begin n_bad++; $display("FAIL srst_busy got %b want 0", a_busy); end
    if (a_cnt !== 8'd0) begin n_bad++; $display("FAIL srst_sweep_cnt got %0d want 0", a_cnt); end
    if (a_symb !== 16'd1) begin n_bad++; $display("FAIL srst_symb got %0d want 1", a_symb); end
    if (a_samp !== 24'd1) begin n_bad++; $display("FAIL srst_samp got %0d want 1", a_samp); end
    do_start(1'b0, 8'd1);
    run(1'b0, 12, 100, 3, 200);
    n_cmp += 2;
    if (q_data.size() !== 12) begin n_bad++; $display("FAIL srst_restart_beats got %0d want 12", q_data.size()); end
    if (done_cnt !== 1) begin n_bad++; $display("FAIL srst_restart_done got %0d want 1", done_cnt); end
    for (int i = 0; i < q_data.size() && i < 12; i++) begin
      n_cmp++;
      if (q_data[i] !== sched_ph(i)) begin n_bad++; $display("FAIL srst_restart_data[%0d] got %h want %h", i, q_data[i], sched_ph(i)); end
    end
  endtask

  // final report
  initial begin
    test_reset();
    test_schedule();
    test_gap_repeat();
    test_backpressure();
    test_wrap();
    test_stop();
    test_srst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
